reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Parametrised scoreboard-based hazard unit for the ID stage, the successor to the fixed two-stage RAW comparator. It tracks a pending write per architectural register with a latency countdown or, for unknown-latency ops such as load-miss or divide, an explicit writeback release. Each cycle it decides whether the instruction in ID must stall, taking forwarding into account. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- REG_AW, 5, register index width; must satisfy 2**REG_AW >= NUM_REGS.
- NUM_SRC, 2, number of source operands checked per instruction.
- LAT_W, 3, latency field width; the maximum fixed latency is 2**LAT_W-1.
- FWD_EN, 1, 1 means the final-cycle result and the same-cycle writeback are bypassed; 0 means no bypass.
- STALL_CW, 32, stall counter width.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset; synchronous, active-high.
- id_rs_i, input, NUM_SRC*REG_AW, source indices; source s occupies bits [s*REG_AW +: REG_AW].
- id_rs_en_i, input, NUM_SRC, per-source valid; this masks immediate fields aliasing rs positions.
- issue_valid_i, input, 1, the ID instruction requests issue.
- issue_we_i, input, 1, the instruction writes rd.
- issue_rd_i, input, REG_AW, destination index.
- issue_lat_i, input, LAT_W, result latency in cycles; 0 means long-latency, released only by writeback.
- wb_valid_i, input, 1, a long-latency result is written back this cycle.
- wb_rd_i, input, REG_AW, writeback destination.
- flush_i, input, 1, the ID instruction is squashed (branch/jump).
- hazard_o, output, 1, stall ID/IF this cycle.
- busy_o, output, NUM_REGS, per-register pending flag for debug; bit 0 is always 0.
- stall_cnt_o, output, STALL_CW, stall cycles counted since reset.

## Operation
- Per-register state: busy, lng (long), cnt[LAT_W-1:0].
- Source s is considered only when id_rs_en_i[s] is set and rs != 0.
- Source s raises a RAW hazard when busy[rs] is set, unless it is bypassable. It is bypassable when FWD_EN and one of:
  - !lng[rs] and cnt[rs]==1;
  - lng[rs] and wb_valid_i and wb_rd_i==rs.
- WAW hazard: issue_valid_i && issue_we_i && issue_rd_i!=0 && busy[issue_rd_i]. Same-cycle bypass does not apply to WAW.
- hazard_o = issue_valid_i && !flush_i && (any RAW || WAW).
- Issue is accepted when issue_valid_i && !hazard_o && !flush_i && issue_we_i && issue_rd_i!=0.
  - Accepted issue with lat L>0 loads busy=1, lng=0, cnt=L.
  - Accepted issue with lat 0 loads busy=1, lng=1, cnt=0.
- Fixed-latency entries decrement cnt each cycle. The entry whose cnt is 1 clears busy on the next edge.
- wb_valid_i clears busy and lng of wb_rd_i only if that entry is lng. Writeback to a non-long, idle, or zero register is ignored.
- Simultaneous events: an accepted issue to register r overrides a decrement or writeback to r in the same cycle. The WAW rule normally prevents this case; issue-wins is the required tie-break.
- stall_cnt_o increments by 1 on every cycle hazard_o=1 and saturates at all-ones (no wrap).
- Reset: all busy, lng, cnt = 0 and stall_cnt_o = 0. Therefore hazard_o=0 and busy_o=0 in the first cycle after reset.
- rst_i asserted mid-operation discards all pending entries; the pipeline is flushed alongside.

## Timing
- hazard_o is combinational from registered state plus the current-cycle inputs. State and busy_o update on the rising edge. stall_cnt_o is registered.
- A producer issued in cycle t with lat L keeps busy high for cycles t+1..t+L.
- A dependent consumer in ID:
  - FWD_EN=1: stalls for cycles t+1..t+L-1 and issues at t+L. With L=1 it never stalls.
  - FWD_EN=0: stalls for cycles t+1..t+L and issues at t+L+1.
- Long-latency entry with writeback at cycle w:
  - FWD_EN=1: the consumer issues at cycle w.
  - FWD_EN=0: the consumer issues at cycle w+1.

## Structure
- Shared package hdu_pkg holds:
  - default parameter constants;
  - the LAT_LONG=0 encoding;
  - a typedef for the per-entry state struct {busy, lng, cnt}.
- One sub-module, sb_entry, implements a single register's state and countdown. It is instantiated for indices 1..NUM_REGS-1 in a generate loop; index 0 is tied off.
- Source comparison and the hazard OR-reduction live in the top level.

## Test plan
- Reset check: assert rst_i for 2 cycles with random inputs, then release. Required: busy_o=0, hazard_o=0, stall_cnt_o=0.
- Fixed latency with FWD_EN=1: issue x5 with lat=3 at cycle 0, consumer rs1=5 from cycle 1. Required: hazard_o=1 in cycles 1–2, 0 in cycle 3, stall_cnt_o=2. The same test with FWD_EN=0 requires stalls in cycles 1–3.
- Long latency: issue x7 with lat=0, consumer reads x7, wb_valid_i for x7 at cycle 10. Required: stall in cycles 1–9, issue at 10 (FWD_EN=1); wb_rd_i=8 on an idle register is ignored.
- x0 and enable masking:
  - issue with rd=0: no entry is created;
  - id_rs_en_i=0 with a matching rs: no stall;
  - flush_i=1 while a hazard is present: hazard_o=0 and no issue is accepted.
- WAW and tie-break:
  - issue x3 with lat=4, then issue x3 again at cycle 1: stall until busy clears;
  - two sources both hazarding: one hazard_o, one count increment.
- Saturation: with STALL_CW=4, hold a stall for 20 cycles. Required: stall_cnt_o stops at 15.

Source files
------------

// File: rtl/hdu_pkg.sv
// Shared constants and per-register state type for the scoreboard hazard unit.
package hdu_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int NUM_SRC_DEF  = 2;
  localparam int LAT_W_DEF    = 3;
  localparam int FWD_EN_DEF   = 1;
  localparam int STALL_CW_DEF = 32;

  // Latency code meaning "unknown latency, released by writeback".
  localparam int LAT_LONG  = 0;
  // Storage width of the countdown; LAT_W must not exceed it.
  localparam int LAT_W_MAX = 8;

  typedef struct packed {
    logic                 busy;
    logic                 lng;
    logic [LAT_W_MAX-1:0] cnt;
  } sb_state_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: pending flag plus either a latency countdown or a
// wait-for-writeback marker.
module sb_entry
  import hdu_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_hit_i,
  input  logic [LAT_W-1:0] issue_lat_i,
  input  logic             wb_hit_i,
  output sb_state_t        state_o
);

  sb_state_t st;

  // A new issue wins over any retirement happening to this slot in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st <= '0;
    end else if (issue_hit_i) begin
      st.busy <= 1'b1;
      st.lng  <= (issue_lat_i == LAT_W'(LAT_LONG));
      st.cnt  <= LAT_W_MAX'(issue_lat_i);
    end else if (st.busy && st.lng) begin
      if (wb_hit_i) begin
        st.busy <= 1'b0;
        st.lng  <= 1'b0;
      end
    end else if (st.busy) begin
      st.cnt <= st.cnt - LAT_W_MAX'(1);
      if (st.cnt == LAT_W_MAX'(1)) st.busy <= 1'b0;
    end
  end

  assign state_o = st;

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage hazard unit: per-register scoreboard, RAW/WAW detection with optional
// bypass awareness, and a saturating stall-cycle counter.
module reg_scoreboard
  import hdu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = NUM_SRC_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int FWD_EN   = FWD_EN_DEF,
  parameter int STALL_CW = STALL_CW_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_en_i,
  input  logic                      issue_valid_i,
  input  logic                      issue_we_i,
  input  logic [REG_AW-1:0]         issue_rd_i,
  input  logic [LAT_W-1:0]          issue_lat_i,
  input  logic                      wb_valid_i,
  input  logic [REG_AW-1:0]         wb_rd_i,
  input  logic                      flush_i,
  output logic                      hazard_o,
  output logic [NUM_REGS-1:0]       busy_o,
  output logic [STALL_CW-1:0]       stall_cnt_o
);

  // Indices past NUM_REGS are tied off so any encodable index can be looked up.
  localparam int NUM_IDX = 2**REG_AW;

  sb_state_t ent [NUM_IDX];
  logic      raw_hit;
  logic      waw_hit;
  logic      hazard;
  logic      accept;

  function automatic logic src_raw(input logic [REG_AW-1:0] idx, input sb_state_t e,
                                   input logic wb_v, input logic [REG_AW-1:0] wb_rd);
    logic byp;
    byp = (FWD_EN != 0) && (e.lng ? (wb_v && (wb_rd == idx)) : (e.cnt == LAT_W_MAX'(1)));
    return (idx != '0) && e.busy && !byp;
  endfunction

  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
    return (&v) ? v : v + STALL_CW'(1);
  endfunction

  assign ent[0] = '0;

  for (genvar i = 1; i < NUM_IDX; i++) begin : g_ent
    if (i < NUM_REGS) begin : g_live
      sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .issue_hit_i (accept && (issue_rd_i == REG_AW'(i))),
        .issue_lat_i (issue_lat_i),
        .wb_hit_i    (wb_valid_i && (wb_rd_i == REG_AW'(i))),
        .state_o     (ent[i])
      );
    end else begin : g_tie
      assign ent[i] = '0;
    end
  end

  always_comb begin
    raw_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_en_i[s] && src_raw(id_rs_i[s*REG_AW +: REG_AW],
                                   ent[id_rs_i[s*REG_AW +: REG_AW]], wb_valid_i, wb_rd_i))
        raw_hit = 1'b1;
    end
  end

  // WAW ignores bypass: the older write must fully retire before a new one is tracked.
  assign waw_hit  = issue_valid_i && issue_we_i && (issue_rd_i != '0) && ent[issue_rd_i].busy;
  assign hazard   = issue_valid_i && !flush_i && (raw_hit || waw_hit);
  assign accept   = issue_valid_i && !hazard && !flush_i && issue_we_i && (issue_rd_i != '0);
  assign hazard_o = hazard;

  always_comb begin
    busy_o = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_o[r] = ent[r].busy;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       stall_cnt_o <= '0;
    else if (hazard) stall_cnt_o <= sat_inc(stall_cnt_o);
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: bypass, no-bypass and narrow-counter instances
// checked against a time-stamp based model of pending register writes.
module tb_reg_scoreboard;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0]    id_rs_en;
  logic             iv, iwe, wbv, flush;
  logic [AW-1:0]    ird, wbrd;
  logic [LW-1:0]    ilat;

  logic          haz_f, haz_n, haz_s;
  logic [NR-1:0] busy_f, busy_n, busy_s;
  logic [31:0]   cnt_f, cnt_n;
  logic [3:0]    cnt_s;

  reg_scoreboard #(.FWD_EN(1), .STALL_CW(32)) dut_f (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rs_en_i(id_rs_en),
    .issue_valid_i(iv), .issue_we_i(iwe), .issue_rd_i(ird), .issue_lat_i(ilat),
    .wb_valid_i(wbv), .wb_rd_i(wbrd), .flush_i(flush),
    .hazard_o(haz_f), .busy_o(busy_f), .stall_cnt_o(cnt_f));

  reg_scoreboard #(.FWD_EN(0), .STALL_CW(32)) dut_n (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rs_en_i(id_rs_en),
    .issue_valid_i(iv), .issue_we_i(iwe), .issue_rd_i(ird), .issue_lat_i(ilat),
    .wb_valid_i(wbv), .wb_rd_i(wbrd), .flush_i(flush),
    .hazard_o(haz_n), .busy_o(busy_n), .stall_cnt_o(cnt_n));

  reg_scoreboard #(.FWD_EN(1), .STALL_CW(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rs_en_i(id_rs_en),
    .issue_valid_i(iv), .issue_we_i(iwe), .issue_rd_i(ird), .issue_lat_i(ilat),
    .wb_valid_i(wbv), .wb_rd_i(wbrd), .flush_i(flush),
    .hazard_o(haz_s), .busy_o(busy_s), .stall_cnt_o(cnt_s));

  // Model: k=0 with bypass, k=1 without. A fixed write is pending up to and
  // including cycle m_done; a long write is pending until its writeback.
  bit m_pend [2][NR];
  bit m_long [2][NR];
  int m_done [2][NR];
  int m_cnt  [2];
  int m_sat;
  int cyc;
  int checks = 0;
  int errors = 0;

  function automatic bit m_hazard(int k);
    bit raw, waw, byp;
    int rs;
    raw = 0;
    for (int s = 0; s < NS; s++) begin
      rs = int'(id_rs[s*AW +: AW]);
      if (id_rs_en[s] && rs != 0 && m_pend[k][rs]) begin
        byp = (k == 0) && (m_long[k][rs] ? (wbv && int'(wbrd) == rs) : (cyc == m_done[k][rs]));
        if (!byp) raw = 1;
      end
    end
    waw = iv && iwe && ird != 0 && m_pend[k][ird];
    return iv && !flush && (raw || waw);
  endfunction

  function automatic logic [NR-1:0] m_busy(int k);
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_pend[k][r];
    return v;
  endfunction

  function automatic void m_update(int k);
    bit h;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_pend[k][r] = 0;
        m_long[k][r] = 0;
      end
      m_cnt[k] = 0;
      if (k == 0) m_sat = 0;
      return;
    end
    h = m_hazard(k);
    if (h) begin
      m_cnt[k]++;
      if (k == 0 && m_sat < 15) m_sat++;
    end
    for (int r = 0; r < NR; r++)
      if (m_pend[k][r] && !m_long[k][r] && cyc >= m_done[k][r]) m_pend[k][r] = 0;
    if (wbv && wbrd != 0 && m_pend[k][wbrd] && m_long[k][wbrd]) begin
      m_pend[k][wbrd] = 0;
      m_long[k][wbrd] = 0;
    end
    if (iv && !h && !flush && iwe && ird != 0) begin
      m_pend[k][ird] = 1;
      m_long[k][ird] = (ilat == 0);
      m_done[k][ird] = cyc + int'(ilat);
    end
  endfunction

  task automatic tick();
    m_update(0);
    m_update(1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    iv = 0; iwe = 0; ird = '0; ilat = '0; id_rs = '0; id_rs_en = '0;
    wbv = 0; wbrd = '0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      iv = 1'($urandom); iwe = 1'($urandom); ird = AW'($urandom); ilat = LW'($urandom);
      id_rs = (NS*AW)'($urandom); id_rs_en = NS'($urandom);
      wbv = 1'($urandom); wbrd = AW'($urandom); flush = 1'($urandom);
      tick();
    end
    rst = 0;
    idle();
    #1;
    checks++; if (busy_f !== '0) begin errors++; $display("FAIL reset_busy_f got=%h exp=0", busy_f); end
    checks++; if (busy_n !== '0) begin errors++; $display("FAIL reset_busy_n got=%h exp=0", busy_n); end
    checks++; if (haz_f !== 1'b0) begin errors++; $display("FAIL reset_haz_f got=%b exp=0", haz_f); end
    checks++; if (haz_n !== 1'b0) begin errors++; $display("FAIL reset_haz_n got=%b exp=0", haz_n); end
    checks++; if (cnt_f !== 32'd0) begin errors++; $display("FAIL reset_cnt_f got=%0d exp=0", cnt_f); end
    checks++; if (cnt_s !== 4'd0) begin errors++; $display("FAIL reset_cnt_s got=%0d exp=0", cnt_s); end
  endtask

  task automatic test_fixed_lat();
    idle();
    iv = 1; iwe = 1; ird = 5'd5; ilat = 3'd3;
    #1;
    checks++; if (haz_f !== 1'b0) begin errors++; $display("FAIL fixed_issue_haz got=%b exp=0", haz_f); end
    tick();
    iwe = 0; ird = '0; ilat = '0; id_rs = {5'd0, 5'd5}; id_rs_en = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++; if (haz_f !== (c <= 2)) begin errors++; $display("FAIL fixed_haz_f c=%0d got=%b exp=%b", c, haz_f, c <= 2); end
      checks++; if (haz_n !== (c <= 3)) begin errors++; $display("FAIL fixed_haz_n c=%0d got=%b exp=%b", c, haz_n, c <= 3); end
      checks++; if (busy_f[5] !== (c <= 3)) begin errors++; $display("FAIL fixed_busy5 c=%0d got=%b exp=%b", c, busy_f[5], c <= 3); end
      tick();
    end
    #1;
    checks++; if (cnt_f !== 32'd2) begin errors++; $display("FAIL fixed_cnt_f got=%0d exp=2", cnt_f); end
    checks++; if (cnt_n !== 32'd3) begin errors++; $display("FAIL fixed_cnt_n got=%0d exp=3", cnt_n); end
  endtask

  task automatic test_long_lat();
    idle();
    iv = 1; iwe = 1; ird = 5'd7; ilat = 3'd0;
    tick();
    iwe = 0; ird = '0; id_rs = {5'd0, 5'd7}; id_rs_en = 2'b01;
    for (int c = 1; c <= 11; c++) begin
      wbv = (c == 4 || c == 10);
      wbrd = (c == 4) ? 5'd8 : 5'd7;
      #1;
      checks++; if (haz_f !== (c <= 9)) begin errors++; $display("FAIL long_haz_f c=%0d got=%b exp=%b", c, haz_f, c <= 9); end
      checks++; if (haz_n !== (c <= 10)) begin errors++; $display("FAIL long_haz_n c=%0d got=%b exp=%b", c, haz_n, c <= 10); end
      if (c == 5) begin
        checks++; if (busy_f[8:7] !== 2'b01) begin errors++; $display("FAIL long_idle_wb got=%b exp=01", busy_f[8:7]); end
      end
      tick();
    end
    idle();
    #1;
    checks++; if (busy_f !== '0) begin errors++; $display("FAIL long_release got=%h exp=0", busy_f); end
    checks++; if (cnt_f !== 32'd11) begin errors++; $display("FAIL long_cnt_f got=%0d exp=11", cnt_f); end
    checks++; if (cnt_n !== 32'd13) begin errors++; $display("FAIL long_cnt_n got=%0d exp=13", cnt_n); end
  endtask

  task automatic test_x0_mask();
    idle();
    iv = 1; iwe = 1; ird = 5'd0; ilat = 3'd3;
    tick();
    #1;
    checks++; if (busy_f !== '0) begin errors++; $display("FAIL x0_no_entry got=%h exp=0", busy_f); end
    ird = 5'd9; ilat = 3'd5;
    tick();
    iwe = 0; ird = '0; id_rs = {5'd0, 5'd9}; id_rs_en = 2'b00;
    #1;
    checks++; if (busy_f[9] !== 1'b1) begin errors++; $display("FAIL x0_busy9 got=%b exp=1", busy_f[9]); end
    checks++; if (haz_n !== 1'b0) begin errors++; $display("FAIL mask_haz got=%b exp=0", haz_n); end
    tick();
    id_rs_en = 2'b01; flush = 1; iwe = 1; ird = 5'd10; ilat = 3'd2;
    #1;
    checks++; if (haz_f !== 1'b0) begin errors++; $display("FAIL flush_haz_f got=%b exp=0", haz_f); end
    checks++; if (haz_n !== 1'b0) begin errors++; $display("FAIL flush_haz_n got=%b exp=0", haz_n); end
    tick();
    flush = 0; iwe = 0; ird = '0; id_rs = '0; id_rs_en = 2'b11;
    #1;
    checks++; if (busy_f[10] !== 1'b0) begin errors++; $display("FAIL flush_no_issue got=%b exp=0", busy_f[10]); end
    checks++; if (haz_n !== 1'b0) begin errors++; $display("FAIL src_x0_haz got=%b exp=0", haz_n); end
    idle();
    for (int i = 0; i < 6; i++) tick();
    #1;
    checks++; if (busy_n !== '0) begin errors++; $display("FAIL x0_drain got=%h exp=0", busy_n); end
    checks++; if (cnt_f !== 32'd11) begin errors++; $display("FAIL x0_cnt_f got=%0d exp=11", cnt_f); end
  endtask

  task automatic test_waw();
    idle();
    iv = 1; iwe = 1; ird = 5'd3; ilat = 3'd4;
    tick();
    ilat = 3'd2;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++; if (haz_f !== (c <= 4)) begin errors++; $display("FAIL waw_haz_f c=%0d got=%b exp=%b", c, haz_f, c <= 4); end
      checks++; if (haz_n !== (c <= 4)) begin errors++; $display("FAIL waw_haz_n c=%0d got=%b exp=%b", c, haz_n, c <= 4); end
      tick();
    end
    ird = 5'd12; ilat = 3'd4;
    #1;
    checks++; if (busy_f[3] !== 1'b1) begin errors++; $display("FAIL waw_reissue got=%b exp=1", busy_f[3]); end
    tick();
    ird = 5'd13;
    tick();
    iwe = 0; ird = '0; id_rs = {5'd13, 5'd12}; id_rs_en = 2'b11;
    #1;
    checks++; if (haz_f !== 1'b1) begin errors++; $display("FAIL two_src_haz got=%b exp=1", haz_f); end
    tick();
    idle();
    #1;
    checks++; if (cnt_f !== 32'd16) begin errors++; $display("FAIL two_src_cnt_f got=%0d exp=16", cnt_f); end
    checks++; if (cnt_n !== 32'd18) begin errors++; $display("FAIL two_src_cnt_n got=%0d exp=18", cnt_n); end
    checks++; if (cnt_s !== 4'd15) begin errors++; $display("FAIL two_src_cnt_s got=%0d exp=15", cnt_s); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom % 4) != 0; iwe = 1'($urandom); ird = AW'($urandom % 16); ilat = LW'($urandom);
      id_rs = {AW'($urandom % 16), AW'($urandom % 16)}; id_rs_en = NS'($urandom);
      wbv = ($urandom % 3) == 0; wbrd = AW'($urandom % 16); flush = ($urandom % 10) == 0;
      #1;
      checks++; if (haz_f !== m_hazard(0)) begin errors++; $display("FAIL rnd_haz_f n=%0d got=%b exp=%b", n, haz_f, m_hazard(0)); end
      checks++; if (haz_n !== m_hazard(1)) begin errors++; $display("FAIL rnd_haz_n n=%0d got=%b exp=%b", n, haz_n, m_hazard(1)); end
      checks++; if (busy_f !== m_busy(0)) begin errors++; $display("FAIL rnd_busy_f n=%0d got=%h exp=%h", n, busy_f, m_busy(0)); end
      checks++; if (busy_n !== m_busy(1)) begin errors++; $display("FAIL rnd_busy_n n=%0d got=%h exp=%h", n, busy_n, m_busy(1)); end
      checks++; if (cnt_f !== 32'(m_cnt[0])) begin errors++; $display("FAIL rnd_cnt_f n=%0d got=%0d exp=%0d", n, cnt_f, m_cnt[0]); end
      checks++; if (cnt_n !== 32'(m_cnt[1])) begin errors++; $display("FAIL rnd_cnt_n n=%0d got=%0d exp=%0d", n, cnt_n, m_cnt[1]); end
      checks++; if (cnt_s !== 4'(m_sat)) begin errors++; $display("FAIL rnd_cnt_s n=%0d got=%0d exp=%0d", n, cnt_s, m_sat); end
      tick();
    end
  endtask

  task automatic test_reset_saturation();
    idle();
    iv = 1; iwe = 1; ird = 5'd20; ilat = 3'd0;
    tick();
    idle();
    #1;
    checks++; if (busy_f[20] !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", busy_f[20]); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (busy_f !== '0) begin errors++; $display("FAIL mid_reset_busy got=%h exp=0", busy_f); end
    checks++; if (cnt_s !== 4'd0) begin errors++; $display("FAIL mid_reset_cnt got=%0d exp=0", cnt_s); end
    iv = 1; iwe = 1; ird = 5'd5; ilat = 3'd0;
    tick();
    iwe = 0; ird = '0; id_rs = {5'd0, 5'd5}; id_rs_en = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      tick();
      #1;
      checks++; if (cnt_s !== 4'((c < 15) ? c : 15)) begin errors++; $display("FAIL sat_cnt_s c=%0d got=%0d exp=%0d", c, cnt_s, (c < 15) ? c : 15); end
      checks++; if (cnt_f !== 32'(c)) begin errors++; $display("FAIL sat_cnt_f c=%0d got=%0d exp=%0d", c, cnt_f, c); end
    end
    wbv = 1; wbrd = 5'd5;
    #1;
    checks++; if (haz_f !== 1'b0) begin errors++; $display("FAIL sat_wb_bypass got=%b exp=0", haz_f); end
    tick();
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    cyc = 0;
    @(negedge clk);
    test_reset();
    test_fixed_lat();
    test_long_lat();
    test_x0_mask();
    test_waw();
    test_random();
    test_reset_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
